// File: rtl/adder_pkg.sv
// Configuration helpers shared by pipelined_adder and adder_slice: parameter
// legality, slice width and signed saturation limits.
package adder_pkg;

    localparam int MAX_WIDTH = 1024;

    function automatic bit cfg_ok(input int width, input int stages);
        return (stages >= 1) && (stages <= width) && (width <= MAX_WIDTH)
            && ((width % stages) == 0);
    endfunction

    function automatic int slice_w(input int width, input int stages);
        return width / stages;
    endfunction

    // Most positive two's-complement value of the given width: 0111..1
    function automatic logic [MAX_WIDTH-1:0] sat_pos(input int width);
        logic [MAX_WIDTH-1:0] v;
        v = '0;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            if (i < width - 1) v[i] = 1'b1;
        end
        return v;
    endfunction

    // Most negative two's-complement value of the given width: 1000..0
    function automatic logic [MAX_WIDTH-1:0] sat_neg(input int width);
        logic [MAX_WIDTH-1:0] v;
        v = '0;
        v[width-1] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational W-bit ripple-carry slice; one instance per pipeline stage.
module adder_slice
    import adder_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co
);

    logic [W:0] c;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no
        // path can leave it unassigned and infer a latch.
        s    = '0;
        c    = '0;
        c[0] = ci;
        for (int i = 0; i < W; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign co = c[W];

endmodule

// File: rtl/pipelined_adder.sv
// Skewed, elastic add/subtract pipeline: stage k adds slice k of the operands.
// Optional build macro ADDER_SATURATE_EN clamps overflowing results.
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             c_out,
    output logic             ovf
);

    localparam int SW  = slice_w(WIDTH, STAGES);
    localparam int MSB = WIDTH - 1;

    if (!cfg_ok(WIDTH, STAGES)) begin : g_cfg_err
        $error("pipelined_adder: need 1 <= STAGES <= WIDTH and WIDTH a multiple of STAGES");
    end

    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] valid_in;
    logic [STAGES-1:0] load;
    logic [STAGES-1:0] ci_in;
    logic [STAGES-1:0] slice_co;

    logic [WIDTH-1:0]  a_in    [STAGES];
    logic [WIDTH-1:0]  b_in    [STAGES];
    logic [WIDTH-1:0]  s_in    [STAGES];
    logic [WIDTH-1:0]  sum_d   [STAGES];
    logic [SW-1:0]     slice_s [STAGES];

    logic [WIDTH-1:0]  opa_q   [STAGES];
    logic [WIDTH-1:0]  opb_q   [STAGES];
    logic [WIDTH-1:0]  sum_q   [STAGES];
    logic              carry_q [STAGES];

    logic [WIDTH-1:0]  out_q;
    logic              c_out_q;
    logic              ovf_q;
    logic [WIDTH-1:0]  res_d;
    logic              ovf_d;

    // A stage may load when it is empty or its occupant leaves this cycle.
    always_comb begin
        logic ready_chain;
        ready_chain = out_ready;
        load        = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            load[k]     = !valid_q[k] || ready_chain;
            ready_chain = load[k];
        end
    end

    assign in_ready = load[0];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign valid_in[k] = in_valid;
            assign a_in[k]     = in1;
            assign b_in[k]     = sub ? ~in2 : in2;
            assign ci_in[k]    = c_in ^ sub;
            assign s_in[k]     = '0;
        end else begin : g_next
            assign valid_in[k] = valid_q[k-1];
            assign a_in[k]     = opa_q[k-1];
            assign b_in[k]     = opb_q[k-1];
            assign ci_in[k]    = carry_q[k-1];
            assign s_in[k]     = sum_q[k-1];
        end

        adder_slice #(.W(SW)) u_slice (
            .a  (a_in[k][k*SW +: SW]),
            .b  (b_in[k][k*SW +: SW]),
            .ci (ci_in[k]),
            .s  (slice_s[k]),
            .co (slice_co[k])
        );

        // Result bits above the slices done so far are still zero.
        assign sum_d[k] = s_in[k] | (WIDTH'(slice_s[k]) << (k * SW));
    end

    assign ovf_d = (a_in[STAGES-1][MSB] == b_in[STAGES-1][MSB])
                && (sum_d[STAGES-1][MSB] != a_in[STAGES-1][MSB]);

`ifdef ADDER_SATURATE_EN
    localparam logic [MAX_WIDTH-1:0] SAT_POS_W = sat_pos(WIDTH);
    localparam logic [MAX_WIDTH-1:0] SAT_NEG_W = sat_neg(WIDTH);
    localparam logic [WIDTH-1:0]     SAT_POS   = SAT_POS_W[WIDTH-1:0];
    localparam logic [WIDTH-1:0]     SAT_NEG   = SAT_NEG_W[WIDTH-1:0];

    assign res_d = !ovf_d ? sum_d[STAGES-1]
                 : (a_in[STAGES-1][MSB] ? SAT_NEG : SAT_POS);
`else
    assign res_d = sum_d[STAGES-1];
`endif

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before the clock edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            out_q   <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (load[k]) valid_q[k] <= valid_in[k];
            end
            if (load[STAGES-1] && valid_in[STAGES-1]) begin
                out_q   <= res_d;
                c_out_q <= slice_co[STAGES-1];
                ovf_q   <= ovf_d;
            end
        end
    end

    // NOTE: intermediate datapath registers carry no reset; their valid bit
    // alone decides whether the contents mean anything.
    always_ff @(posedge clk) begin
        for (int k = 0; k < STAGES - 1; k++) begin
            if (load[k] && valid_in[k]) begin
                opa_q[k]   <= a_in[k];
                opb_q[k]   <= b_in[k];
                carry_q[k] <= slice_co[k];
                sum_q[k]   <= sum_d[k];
            end
        end
    end

    assign out_valid = valid_q[STAGES-1];
    assign out       = out_q;
    assign c_out     = c_out_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed and random checks of pipelined_adder (WIDTH=32, STAGES=4), including
// backpressure, reset flush and, when ADDER_SATURATE_EN is defined, clamping.
module tb_pipelined_adder;

    localparam int WIDTH  = 32;
    localparam int STAGES = 4;

`ifdef ADDER_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] res;
        logic        c;
        logic        v;
    } res_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in1;
    logic [31:0] in2;
    logic        c_in;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out;
    logic        c_out;
    logic        ovf;

    int   n_checks = 0;
    int   n_errors = 0;
    res_t exp_q[$];

    pipelined_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in1       (in1),
        .in2       (in2),
        .c_in      (c_in),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .c_out     (c_out),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    // Reference: straight 33-bit arithmetic on the effective operands.
    function automatic res_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic ci, input logic s);
        logic [32:0] full;
        logic [31:0] bb;
        logic        cc;
        res_t        r;
        bb    = s ? ~b : b;
        cc    = s ? ~ci : ci;
        full  = {1'b0, a} + {1'b0, bb} + {32'd0, cc};
        r.res = full[31:0];
        r.c   = full[32];
        r.v   = (a[31] == bb[31]) && (full[31] != a[31]);
        if (SAT && r.v) r.res = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        return r;
    endfunction

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in1 = '0; in2 = '0; c_in = 1'b0; sub = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        n_checks++;
        if ({out, c_out, ovf} !== 34'd0) begin
            n_errors++; $display("FAIL reset_outputs: got %h/%b/%b expected 0/0/0", out, c_out, ovf);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    // One isolated operation: checks acceptance, latency and the result.
    task automatic single_op(input string name, input logic [31:0] a, input logic [31:0] b,
                             input logic ci, input logic s, input logic [31:0] e_out,
                             input logic e_c, input logic e_v);
        int lat;
        out_ready = 1'b1;
        in_valid = 1'b1; in1 = a; in2 = b; c_in = ci; sub = s;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_errors++; $display("FAIL %s_accept: in_ready got %b expected 1", name, in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        n_checks++;
        if (lat != STAGES) begin
            n_errors++; $display("FAIL %s_latency: got %0d expected %0d", name, lat, STAGES);
        end
        n_checks++;
        if (out !== e_out) begin
            n_errors++; $display("FAIL %s_out: got %h expected %h", name, out, e_out);
        end
        n_checks++;
        if (c_out !== e_c || ovf !== e_v) begin
            n_errors++; $display("FAIL %s_flags: got c_out=%b ovf=%b expected c_out=%b ovf=%b",
                                 name, c_out, ovf, e_c, e_v);
        end
        @(posedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_errors++; $display("FAIL %s_drained: out_valid got %b expected 0", name, out_valid);
        end
    endtask

    task automatic test_carry_chain;
        single_op("carry_all_slices", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0,
                  32'h0000_0000, 1'b1, 1'b0);
        single_op("carry_in_add", 32'h0000_FFFF, 32'h00FF_0000, 1'b1, 1'b0,
                  32'h0100_0000, 1'b0, 1'b0);
    endtask

    task automatic test_subtract;
        single_op("sub_5_minus_7", 32'd5, 32'd7, 1'b0, 1'b1,
                  32'hFFFF_FFFE, 1'b0, 1'b0);
        single_op("sub_borrow_in", 32'd0, 32'd0, 1'b1, 1'b1,
                  32'hFFFF_FFFF, 1'b0, 1'b0);
    endtask

    task automatic test_overflow;
        single_op("sub_overflow", 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1,
                  SAT ? 32'h8000_0000 : 32'h7FFF_FFFF, 1'b1, 1'b1);
        single_op("add_overflow", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0,
                  SAT ? 32'h7FFF_FFFF : 32'h8000_0000, 1'b0, 1'b1);
    endtask

    task automatic test_back_to_back;
        int   sent = 0, got = 0, c = 0, last = -1, ready_low = 0;
        res_t e;
        exp_q.delete();
        out_ready = 1'b1;
        while (got < 100 && c < 400) begin
            if (sent < 100) begin
                in_valid = 1'b1; in1 = $urandom(); in2 = $urandom();
                c_in = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (in_valid && in_ready !== 1'b1) ready_low++;
            if (out_valid === 1'b1) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++; $display("FAIL b2b_unexpected: result %h with nothing outstanding", out);
                end else begin
                    e = exp_q.pop_front();
                    if ({out, c_out, ovf} !== e) begin
                        n_errors++; $display("FAIL b2b_result_%0d: got %h/%b/%b expected %h/%b/%b",
                                             got, out, c_out, ovf, e.res, e.c, e.v);
                    end
                end
                got++;
                last = c;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(in1, in2, c_in, sub));
                sent++;
            end
            @(posedge clk); #1;
            c++;
        end
        in_valid = 1'b0;
        n_checks++;
        if (ready_low != 0) begin
            n_errors++; $display("FAIL b2b_in_ready: low in %0d cycles expected 0", ready_low);
        end
        n_checks++;
        if (got != 100) begin
            n_errors++; $display("FAIL b2b_count: got %0d results expected 100", got);
        end
        n_checks++;
        if (last != 100 + STAGES - 1) begin
            n_errors++; $display("FAIL b2b_throughput: last result in cycle %0d expected %0d",
                                 last, 100 + STAGES - 1);
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] ta [5] = '{32'h1234_5678, 32'hFFFF_0000, 32'h0000_0001, 32'h8000_0000, 32'h7FFF_FFFF};
        logic [31:0] tb [5] = '{32'h1111_1111, 32'h0001_0000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h8000_0000};
        logic [4:0]  tci = 5'b01010;
        logic [4:0]  tsb = 5'b00110;
        int   acc = 0, n = 0;
        res_t e;
        exp_q.delete();
        out_ready = 1'b0;
        for (int c = 0; c < 8; c++) begin
            in_valid = 1'b1;
            in1 = ta[acc % 5]; in2 = tb[acc % 5]; c_in = tci[acc % 5]; sub = tsb[acc % 5];
            #1;
            n_checks++;
            if (in_ready !== (c < STAGES)) begin
                n_errors++; $display("FAIL bp_in_ready_cycle%0d: got %b expected %b",
                                     c, in_ready, (c < STAGES));
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(in1, in2, c_in, sub));
                acc++;
            end
            @(posedge clk); #1;
        end
        n_checks++;
        if (acc != STAGES) begin
            n_errors++; $display("FAIL bp_accepted: got %0d expected %0d", acc, STAGES);
        end
        // Full pipe: accept and drain in the same cycle.
        in_valid = 1'b1; in1 = ta[4]; in2 = tb[4]; c_in = tci[4]; sub = tsb[4];
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b1) begin
            n_errors++; $display("FAIL bp_simultaneous: in_ready=%b out_valid=%b expected 1/1",
                                 in_ready, out_valid);
        end
        if (in_ready) exp_q.push_back(model(in1, in2, c_in, sub));
        while (exp_q.size() > 0 && n < 20) begin
            if (out_valid === 1'b1) begin
                e = exp_q.pop_front();
                n_checks++;
                if ({out, c_out, ovf} !== e) begin
                    n_errors++; $display("FAIL bp_drain: got %h/%b/%b expected %h/%b/%b",
                                         out, c_out, ovf, e.res, e.c, e.v);
                end
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
            n++;
        end
        n_checks++;
        if (exp_q.size() != 0 || out_valid !== 1'b0) begin
            n_errors++; $display("FAIL bp_complete: left %0d, out_valid=%b expected 0/0",
                                 exp_q.size(), out_valid);
        end
    endtask

    task automatic test_reset_flush;
        int stale = 0;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in1 = 32'h0000_0010 + i; in2 = 32'h0000_0100; c_in = 1'b0; sub = 1'b0;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_errors++; $display("FAIL flush_stalled: out_valid got %b expected 1", out_valid);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_errors++; $display("FAIL flush_handshake: out_valid=%b in_ready=%b expected 0/1",
                                 out_valid, in_ready);
        end
        n_checks++;
        if ({out, c_out, ovf} !== 34'd0) begin
            n_errors++; $display("FAIL flush_outputs: got %h/%b/%b expected 0/0/0", out, c_out, ovf);
        end
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) stale++;
        end
        n_checks++;
        if (stale != 0) begin
            n_errors++; $display("FAIL flush_stale: %0d stale results expected 0", stale);
        end
        single_op("post_reset", 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0,
                  32'h2345_6789, 1'b0, 1'b0);
    endtask

    task automatic test_random_flow;
        int   sent = 0, got = 0, cyc = 0;
        bit   prev_stall = 1'b0, accepted;
        logic [33:0] prev_res = '0;
        res_t e;
        exp_q.delete();
        in_valid = 1'b0;
        while (got < 10000 && cyc < 80000) begin
            out_ready = 1'($urandom_range(0, 1));
            if (!in_valid && sent < 10000 && $urandom_range(0, 1) == 1) begin
                in_valid = 1'b1; in1 = $urandom(); in2 = $urandom();
                c_in = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
            end
            #1;
            if (prev_stall) begin
                n_checks++;
                if (out_valid !== 1'b1 || {out, c_out, ovf} !== prev_res) begin
                    n_errors++; $display("FAIL rand_stall_hold: got %b %h expected 1 %h",
                                         out_valid, {out, c_out, ovf}, prev_res);
                end
            end
            if (out_valid === 1'b1 && out_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++; $display("FAIL rand_unexpected: result %h with nothing outstanding", out);
                end else begin
                    e = exp_q.pop_front();
                    if ({out, c_out, ovf} !== e) begin
                        n_errors++; $display("FAIL rand_result_%0d: got %h/%b/%b expected %h/%b/%b",
                                             got, out, c_out, ovf, e.res, e.c, e.v);
                    end
                end
                got++;
            end
            prev_stall = (out_valid === 1'b1) && !out_ready;
            prev_res   = {out, c_out, ovf};
            accepted   = in_valid && in_ready;
            if (accepted) begin
                exp_q.push_back(model(in1, in2, c_in, sub));
                sent++;
            end
            @(posedge clk); #1;
            cyc++;
            if (accepted) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        n_checks++;
        if (got != 10000 || exp_q.size() != 0) begin
            n_errors++; $display("FAIL rand_count: got %0d results, %0d outstanding, expected 10000/0",
                                 got, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_carry_chain();
        test_subtract();
        test_overflow();
        test_back_to_back();
        test_backpressure();
        test_reset_flush();
        test_random_flow();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
